// File: rtl/form_trans_8_32_if.sv
// Byte-in / word-out bundle of the 8-to-32 frame reassembler.
//   din_8bit, din_8bit_en         : byte stream from the link receiver
//   dout_33bit, dout_33bit_en     : {sof, word} toward the frame FIFO
//   frame_done, frame_err         : end-of-frame and abort/drop pulses
// The slave modport is the reassembler; the master modport is the byte source
// and word sink around it.
interface form_trans_8_32_if;
    logic [7:0]  din_8bit;
    logic        din_8bit_en;
    logic [32:0] dout_33bit;
    logic        dout_33bit_en;
    logic        frame_done;
    logic        frame_err;

    modport master (
        output din_8bit, din_8bit_en,
        input  dout_33bit, dout_33bit_en, frame_done, frame_err
    );

    modport slave (
        input  din_8bit, din_8bit_en,
        output dout_33bit, dout_33bit_en, frame_done, frame_err
    );
endinterface

// File: rtl/form_trans_8_32.sv
// Receive-side frame reassembler: collects a contiguous big-endian byte stream
// laid out as MAC_H(4) MAC_L(2) IP(4) PORT(4->2) DATA(4*DATA_WORDS) and emits
// 33-bit words {sof, word}. After a frame ends or aborts, GAP_CYCLES idle
// cycles are required before a new frame is accepted.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   bus            : byte input / word output bundle (slave side)
//   current_state  : FSM state (test port)
//   byte_cnt       : byte index within the current field (test port)
//   word_cnt       : words emitted in the current frame (test port)
module form_trans_8_32 #(
    parameter int DATA_WORDS = 47,
    parameter int GAP_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst,
    form_trans_8_32_if.slave   bus,
    output logic [3:0]         current_state,
    output logic [1:0]         byte_cnt,
    output logic [5:0]         word_cnt
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_MAC_H  = 4'd1;
    localparam logic [3:0] S_MAC_L  = 4'd2;
    localparam logic [3:0] S_IP     = 4'd3;
    localparam logic [3:0] S_PORT   = 4'd4;
    localparam logic [3:0] S_DATA   = 4'd5;
    localparam logic [3:0] S_GAP    = 4'd6;

    // Four header words precede the payload, so the final payload word is
    // being emitted while word_cnt still reads DATA_WORDS+3.
    localparam logic [5:0] LAST_WORD = 6'(DATA_WORDS + 3);
    localparam logic [5:0] GAP_LAST  = 6'(GAP_CYCLES - 1);

    logic [23:0] shreg;
    logic [5:0]  gap_cnt;
    logic [32:0] dout;
    logic        dout_en;
    logic        done;
    logic        err;

    logic        two_byte;
    logic        last_byte;
    logic [32:0] word_next;

    // Only the three most recent bytes are kept; the fourth byte of a word is
    // taken straight from the input on the capturing edge.
    always_comb begin
        two_byte  = (current_state == S_MAC_L) || (current_state == S_PORT);
        last_byte = two_byte ? (byte_cnt == 2'd1) : (byte_cnt == 2'd3);
        word_next = {1'b0, shreg, bus.din_8bit};
        if (current_state == S_MAC_H) begin
            word_next = {1'b1, shreg, bus.din_8bit};
        end else if (two_byte) begin
            word_next = {17'h0_0000, shreg[7:0], bus.din_8bit};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            current_state <= S_IDLE;
            byte_cnt      <= 2'd0;
            word_cnt      <= 6'd0;
            gap_cnt       <= 6'd0;
            shreg         <= 24'h0;
            dout          <= 33'h0;
            dout_en       <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            dout_en <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            case (current_state)
                S_IDLE: begin
                    byte_cnt <= 2'd0;
                    if (bus.din_8bit_en) begin
                        shreg         <= {shreg[15:0], bus.din_8bit};
                        byte_cnt      <= 2'd1;
                        word_cnt      <= 6'd0;
                        current_state <= S_MAC_H;
                    end
                end
                S_MAC_H, S_MAC_L, S_IP, S_PORT, S_DATA: begin
                    if (!bus.din_8bit_en) begin
                        // Abort: partial word is dropped, emitted words stand.
                        err           <= 1'b1;
                        byte_cnt      <= 2'd0;
                        gap_cnt       <= 6'd0;
                        current_state <= S_GAP;
                    end else begin
                        shreg <= {shreg[15:0], bus.din_8bit};
                        if (last_byte) begin
                            dout     <= word_next;
                            dout_en  <= 1'b1;
                            word_cnt <= word_cnt + 6'd1;
                            byte_cnt <= 2'd0;
                            if (current_state != S_DATA) begin
                                current_state <= current_state + 4'd1;
                            end else if (word_cnt == LAST_WORD) begin
                                done          <= 1'b1;
                                gap_cnt       <= 6'd0;
                                current_state <= S_GAP;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                S_GAP: begin
                    if (bus.din_8bit_en) begin
                        // Byte inside the gap is dropped and the gap restarts.
                        err     <= 1'b1;
                        gap_cnt <= 6'd0;
                    end else if (gap_cnt == GAP_LAST) begin
                        gap_cnt       <= 6'd0;
                        current_state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 6'd1;
                    end
                end
                default: begin
                    current_state <= S_IDLE;
                    byte_cnt      <= 2'd0;
                    gap_cnt       <= 6'd0;
                end
            endcase
        end
    end

    assign bus.dout_33bit    = dout;
    assign bus.dout_33bit_en = dout_en;
    assign bus.frame_done    = done;
    assign bus.frame_err     = err;

endmodule
